hilo_muldiv: RTL

- Iterative multiply/divide unit that owns and writes the HI and LO registers. It is the producer side of the HI/LO values that the operand-select stage reads as second-operand sources.
- Executes MULT, MULTU, DIV, DIVU as 32-iteration sequential operations and MTHI/MTLO as single-cycle writes.
- A start/busy/done handshake tells the pipeline control when to stall reads of HI/LO.

---
 rtl/hilo_muldiv.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv
// Brief    : Iterative multiply/divide unit owning the HI/LO registers.
//            MULT/MULTU/DIV/DIVU run one iteration per cycle on unsigned
//            magnitudes with a final sign-fix cycle. MTHI/MTLO write in one
//            cycle. busy/done give the pipeline its stall handshake.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW        = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST    = CW'(WIDTH - 1);
  localparam logic [2:0]    C_OP_MTHI = 3'b100;
  localparam logic [2:0]    C_OP_MTLO = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_accept;
  logic               w_mthi;
  logic               w_mtlo;

  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_m;        // multiplicand (mul) or divisor (div)
  logic [2*WIDTH-1:0] r_acc;      // mul: product:multiplier, div: rem:quotient
  logic               r_is_div;
  logic               r_neg_lo;   // negate product (mul) or quotient (div)
  logic               r_neg_hi;   // negate remainder (div only)

  // Operand conditioning: signed ops (op[0]==0) work on magnitudes
  logic               w_signed;
  logic               w_rs_neg;
  logic               w_rt_neg;
  logic [WIDTH-1:0]   w_rs_mag;
  logic [WIDTH-1:0]   w_rt_mag;
  logic               w_rt_zero;

  assign w_signed  = ~op[0];
  assign w_rs_neg  = w_signed & rs_val[WIDTH-1];
  assign w_rt_neg  = w_signed & rt_val[WIDTH-1];
  assign w_rs_mag  = w_rs_neg ? -rs_val : rs_val;
  assign w_rt_mag  = w_rt_neg ? -rt_val : rt_val;
  assign w_rt_zero = (rt_val == '0);

  // One shift-add multiply step: add multiplicand into the upper half when
  // the current multiplier bit is set, then shift the whole accumulator right.
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;

  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // One restoring divide step: shift the next dividend bit into the
  // remainder, keep the difference only when it does not go negative.
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_div_next;

  assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_diff  = w_div_shift - {1'b0, r_m};
  assign w_div_next  = w_div_diff[WIDTH]
                     ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                     : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

  // Sign-corrected results presented during the FIX cycle
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_prod = r_neg_lo ? -r_acc : r_acc;
  assign w_quo  = r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  // Next-state logic and request decode; starts are only honoured in IDLE
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_mthi       = 1'b0;
    w_mtlo       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (!op[2]) begin
            w_accept     = 1'b1;
            w_state_next = S_RUN;
          end else if (op == C_OP_MTHI) begin
            w_mthi = 1'b1;
          end else if (op == C_OP_MTLO) begin
            w_mtlo = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (r_count == C_LAST) begin
          w_state_next = S_FIX;
        end
      end
      S_FIX: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Iterative datapath: operand latch on accept, one step per RUN cycle.
  // Divide by zero is run unsigned on the raw dividend so the natural
  // result (remainder = dividend, quotient = all ones) needs no fixup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_m      <= '0;
      r_acc    <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
    end else if (w_accept) begin
      r_count  <= '0;
      r_is_div <= op[1];
      if (op[1]) begin
        if (w_rt_zero) begin
          r_m      <= '0;
          r_acc    <= {{WIDTH{1'b0}}, rs_val};
          r_neg_lo <= 1'b0;
          r_neg_hi <= 1'b0;
        end else begin
          r_m      <= w_rt_mag;
          r_acc    <= {{WIDTH{1'b0}}, w_rs_mag};
          r_neg_lo <= w_rs_neg ^ w_rt_neg;
          r_neg_hi <= w_rs_neg;
        end
      end else begin
        r_m      <= w_rs_mag;
        r_acc    <= {{WIDTH{1'b0}}, w_rt_mag};
        r_neg_lo <= w_rs_neg ^ w_rt_neg;
        r_neg_hi <= 1'b0;
      end
    end else if (r_state == S_RUN) begin
      r_count <= r_count + CW'(1);
      r_acc   <= r_is_div ? w_div_next : w_mul_next;
    end
  end

  // HI/LO registers and the busy/done handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi   <= '0;
      lo   <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= (r_state == S_FIX);
      if (w_accept) begin
        busy <= 1'b1;
      end else if (r_state == S_FIX) begin
        busy <= 1'b0;
      end
      if (w_mthi) begin
        hi <= rs_val;
      end else if (r_state == S_FIX) begin
        hi <= r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
      end
      if (w_mtlo) begin
        lo <= rs_val;
      end else if (r_state == S_FIX) begin
        lo <= r_is_div ? w_quo : w_prod[WIDTH-1:0];
      end
    end
  end

endmodule
`default_nettype wire
